alu_instruction_sequencer: RTL and testbench

- Parametrised successor to the combinational ALU opcode decoder.
- Accepts instruction words (opcode plus repeat count) over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues each opcode's registered 13-bit control word to the ALU datapath for (repeat+1) consecutive cycles, honouring a datapath stall.
- Sits between the host/command interface and the primary/secondary/bit-counter/comparator datapath muxes.

---
 rtl/alu_instruction_sequencer.sv | 179 +++++++++++++++++
 tb/tb_alu_instruction_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instruction_sequencer.sv
// Instruction sequencer: buffers {repeat, opcode} words in a FIFO and issues each
// opcode's 13-bit ALU control word for repeat+1 cycles. Optional macro: ALU_ILLEGAL_OPCODE_TRAP_EN.
module alu_instruction_sequencer #(
  parameter int DEPTH    = 4,
  parameter int REPEAT_W = 5,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                instr_valid_i,
  output logic                instr_ready_o,
  input  logic [3:0]          instr_opcode_i,
  input  logic [REPEAT_W-1:0] instr_repeat_i,
  input  logic                stall_i,
  output logic                ctrl_valid_o,
  output logic [2:0]          primary_register_control_o,
  output logic [1:0]          secondary_register_control_o,
  output logic [1:0]          bit_counter_register_control_o,
  output logic                comparator_register_control_o,
  output logic                comparator_demux_control_o,
  output logic                passthrough_demux_control_o,
  output logic [1:0]          output_demux_control_o,
  output logic                input_demux_control_o,
  output logic                busy_o,
  output logic [CNT_W-1:0]    fifo_count_o
`ifdef ALU_ILLEGAL_OPCODE_TRAP_EN
  ,
  output logic                illegal_opcode_o
`endif
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = REPEAT_W + 4;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  function automatic logic [12:0] decode(input logic [3:0] opcode);
    case (opcode)
      4'h0:    decode = 13'h1C00;
      4'h1:    decode = 13'h1800;
      4'h2:    decode = 13'h090A;
      4'h3:    decode = 13'h0450;
      4'h4:    decode = 13'h0300;
      4'h5:    decode = 13'h0200;
      4'h6:    decode = 13'h0100;
      4'h7:    decode = 13'h1C05;
      4'h8:    decode = 13'h1C07;
      4'h9:    decode = 13'h0080;
      4'hA:    decode = 13'h0020;
      4'hB:    decode = 13'h0002;
      4'hC:    decode = 13'h000A;
      4'hD:    decode = 13'h0010;
      4'hE:    decode = 13'h0000;
      default: decode = 13'h000A; // F: primary pass-through when not trapped
    endcase
  endfunction

  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  state_t              state_q, state_d;
  logic [REPEAT_W-1:0] rep_cnt_q;
  logic [12:0]         word_q;

  logic                clear;
  logic                empty;
  logic                push;
  logic                pop;
  logic                load;
  logic                dec;
  logic                illegal_pop;
  logic [ENTRY_W-1:0]  head;
  logic [3:0]          head_opcode;
  logic [REPEAT_W-1:0] head_repeat;
  logic [12:0]         ctrl_word;

  assign clear         = rst_i | flush_i;
  assign empty         = (count_q == '0);
  assign instr_ready_o = !rst_i && (count_q != FULL_CNT);
  assign push          = instr_valid_i & instr_ready_o & ~flush_i;
  assign head          = mem[rd_ptr_q];
  assign head_opcode   = head[3:0];
  assign head_repeat   = head[ENTRY_W-1:4];

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    pop         = 1'b0;
    load        = 1'b0;
    dec         = 1'b0;
`ifdef ALU_ILLEGAL_OPCODE_TRAP_EN
    illegal_pop = (head_opcode == 4'hF);
`else
    illegal_pop = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (!illegal_pop) begin
            load    = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!stall_i) begin
          if (rep_cnt_q != '0) begin
            dec = 1'b1;
          end else if (!empty) begin
            // Back-to-back issue; a trapped opcode ends the issue and the next
            // instruction is picked up from IDLE one cycle later.
            pop = 1'b1;
            if (illegal_pop) state_d = IDLE;
            else             load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the storage array has no reset; occupancy is tracked by pointers and count only.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= {instr_repeat_i, instr_opcode_i};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (clear) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rep_cnt_q <= '0;
      word_q    <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (load) begin
        word_q    <= decode(head_opcode);
        rep_cnt_q <= head_repeat;
      end else if (dec) begin
        rep_cnt_q <= rep_cnt_q - REPEAT_W'(1);
      end
    end
  end

`ifdef ALU_ILLEGAL_OPCODE_TRAP_EN
  always_ff @(posedge clk_i) begin
    if (clear)                    illegal_opcode_o <= 1'b0;
    else if (pop && illegal_pop)  illegal_opcode_o <= 1'b1;
  end
`endif

  assign ctrl_valid_o = (state_q == ISSUE);
  assign ctrl_word    = ctrl_valid_o ? word_q : 13'h0000;
  assign busy_o       = ctrl_valid_o | !empty;
  assign fifo_count_o = count_q;

  assign primary_register_control_o     = ctrl_word[12:10];
  assign secondary_register_control_o   = ctrl_word[9:8];
  assign bit_counter_register_control_o = ctrl_word[7:6];
  assign comparator_register_control_o  = ctrl_word[5];
  assign comparator_demux_control_o     = ctrl_word[4];
  assign passthrough_demux_control_o    = ctrl_word[3];
  assign output_demux_control_o         = ctrl_word[2:1];
  assign input_demux_control_o          = ctrl_word[0];

endmodule

// File: tb/tb_alu_instruction_sequencer.sv
// Self-checking bench for alu_instruction_sequencer: directed scenarios plus random
// traffic compared against a queue-based issue model.
module tb_alu_instruction_sequencer;

  localparam int DEPTH    = 4;
  localparam int REPEAT_W = 5;
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int ENTRY_W  = REPEAT_W + 4;
`ifdef ALU_ILLEGAL_OPCODE_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                flush_i = 1'b0;
  logic                instr_valid_i = 1'b0;
  logic                instr_ready_o;
  logic [3:0]          instr_opcode_i = '0;
  logic [REPEAT_W-1:0] instr_repeat_i = '0;
  logic                stall_i = 1'b0;
  logic                ctrl_valid_o;
  logic [2:0]          primary_register_control_o;
  logic [1:0]          secondary_register_control_o;
  logic [1:0]          bit_counter_register_control_o;
  logic                comparator_register_control_o;
  logic                comparator_demux_control_o;
  logic                passthrough_demux_control_o;
  logic [1:0]          output_demux_control_o;
  logic                input_demux_control_o;
  logic                busy_o;
  logic [CNT_W-1:0]    fifo_count_o;
`ifdef ALU_ILLEGAL_OPCODE_TRAP_EN
  logic                illegal_opcode_o;
`endif
  logic [12:0]         got_word;

  always #5 clk_i = ~clk_i;

  alu_instruction_sequencer #(.DEPTH(DEPTH), .REPEAT_W(REPEAT_W)) dut (
    .clk_i                          (clk_i),
    .rst_i                          (rst_i),
    .flush_i                        (flush_i),
    .instr_valid_i                  (instr_valid_i),
    .instr_ready_o                  (instr_ready_o),
    .instr_opcode_i                 (instr_opcode_i),
    .instr_repeat_i                 (instr_repeat_i),
    .stall_i                        (stall_i),
    .ctrl_valid_o                   (ctrl_valid_o),
    .primary_register_control_o     (primary_register_control_o),
    .secondary_register_control_o   (secondary_register_control_o),
    .bit_counter_register_control_o (bit_counter_register_control_o),
    .comparator_register_control_o  (comparator_register_control_o),
    .comparator_demux_control_o     (comparator_demux_control_o),
    .passthrough_demux_control_o    (passthrough_demux_control_o),
    .output_demux_control_o         (output_demux_control_o),
    .input_demux_control_o          (input_demux_control_o),
    .busy_o                         (busy_o),
    .fifo_count_o                   (fifo_count_o)
`ifdef ALU_ILLEGAL_OPCODE_TRAP_EN
    ,
    .illegal_opcode_o               (illegal_opcode_o)
`endif
  );

  assign got_word = {primary_register_control_o, secondary_register_control_o,
                     bit_counter_register_control_o, comparator_register_control_o,
                     comparator_demux_control_o, passthrough_demux_control_o,
                     output_demux_control_o, input_demux_control_o};

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending instructions in a queue, plus the number of issue
  // cycles still owed to the instruction currently on the outputs.
  logic [12:0]        dec_tbl [16];
  logic [ENTRY_W-1:0] fifo_m [$];
  int                 remaining_m = 0;
  logic [12:0]        word_m = '0;
  logic               illegal_m = 1'b0;

  initial begin
    dec_tbl[0]  = 13'h1C00; dec_tbl[1]  = 13'h1800; dec_tbl[2]  = 13'h090A; dec_tbl[3]  = 13'h0450;
    dec_tbl[4]  = 13'h0300; dec_tbl[5]  = 13'h0200; dec_tbl[6]  = 13'h0100; dec_tbl[7]  = 13'h1C05;
    dec_tbl[8]  = 13'h1C07; dec_tbl[9]  = 13'h0080; dec_tbl[10] = 13'h0020; dec_tbl[11] = 13'h0002;
    dec_tbl[12] = 13'h000A; dec_tbl[13] = 13'h0010; dec_tbl[14] = 13'h0000; dec_tbl[15] = 13'h000A;
  end

  task automatic model_edge(input bit push, input logic [ENTRY_W-1:0] entry,
                            input bit stall, input bit clear);
    logic [ENTRY_W-1:0] e;
    if (clear) begin
      fifo_m.delete();
      remaining_m = 0;
      word_m      = '0;
      illegal_m   = 1'b0;
      return;
    end
    if (remaining_m > 1) begin
      if (!stall) remaining_m--;
    end else if (remaining_m == 0 || !stall) begin
      if (fifo_m.size() > 0) begin
        e = fifo_m.pop_front();
        if (TRAP && e[3:0] == 4'hF) begin
          illegal_m   = 1'b1;
          remaining_m = 0;
        end else begin
          remaining_m = int'(e[ENTRY_W-1:4]) + 1;
          word_m      = dec_tbl[e[3:0]];
        end
      end else begin
        remaining_m = 0;
      end
    end
    if (push) fifo_m.push_back(entry);
  endtask

  // One clock: drive inputs, check ready, advance the model, check outputs after the edge.
  task automatic step(input logic v, input logic [3:0] op, input logic [REPEAT_W-1:0] rep,
                      input logic st, input logic fl, input logic rs);
    logic exp_ready;
    @(negedge clk_i);
    instr_valid_i  = v;
    instr_opcode_i = op;
    instr_repeat_i = rep;
    stall_i        = st;
    flush_i        = fl;
    rst_i          = rs;
    #1;
    exp_ready = !rs && (fifo_m.size() < DEPTH);
    check("ready", {31'd0, instr_ready_o}, {31'd0, exp_ready});
    model_edge(v && exp_ready && !fl, {rep, op}, st, fl || rs);
    @(posedge clk_i);
    #1;
    check("ctrl_valid", {31'd0, ctrl_valid_o}, {31'd0, remaining_m > 0});
    check("ctrl_word", {19'd0, got_word}, {19'd0, (remaining_m > 0) ? word_m : 13'h0000});
    check("fifo_count", 32'(fifo_count_o), 32'(fifo_m.size()));
    check("busy", {31'd0, busy_o}, {31'd0, (remaining_m > 0) || (fifo_m.size() != 0)});
`ifdef ALU_ILLEGAL_OPCODE_TRAP_EN
    check("illegal", {31'd0, illegal_opcode_o}, {31'd0, illegal_m});
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push1(input logic [3:0] op, input logic [REPEAT_W-1:0] rep, input logic st);
    step(1'b1, op, rep, st, 1'b0, 1'b0);
  endtask

  initial begin
    int          vcount;
    int          gaps;
    logic        prev_v;
    logic [12:0] words [$];
    logic [3:0]  rop;
    logic [REPEAT_W-1:0] rrep;

    // Reset held two cycles with a valid instruction offered.
    step(1'b1, 4'h8, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'h8, '0, 1'b0, 1'b0, 1'b1);
    check("rst_ready", {31'd0, instr_ready_o}, 32'd0);
    check("rst_count", 32'(fifo_count_o), 32'd0);
    check("rst_word", {19'd0, got_word}, 32'd0);
    idle(1);
    check("rst_nothing_accepted", {31'd0, busy_o}, 32'd0);

    // Single issue of opcode 8: one cycle of 1C07, then idle.
    push1(4'h8, '0, 1'b0);
    check("single_pending", {31'd0, ctrl_valid_o}, 32'd0);
    idle(1);
    check("single_word", {19'd0, got_word}, 32'h1C07);
    check("single_valid", {31'd0, ctrl_valid_o}, 32'd1);
    idle(1);
    check("single_end_valid", {31'd0, ctrl_valid_o}, 32'd0);
    check("single_end_busy", {31'd0, busy_o}, 32'd0);

    // Opcode 3, repeat 2, two stalled cycles: 0450 for exactly five cycles.
    push1(4'h3, 5'd2, 1'b0);
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'h0, '0, (i == 2 || i == 3), 1'b0, 1'b0);
      if (ctrl_valid_o && got_word == 13'h0450) vcount++;
    end
    check("stall_issue_cycles", 32'(vcount), 32'd5);

    // Five pushes under stall fill the FIFO; then drain in order without gaps.
    push1(4'h0, 5'd3, 1'b1);
    push1(4'h1, 5'd3, 1'b1);
    push1(4'h2, 5'd3, 1'b1);
    push1(4'h4, 5'd3, 1'b1);
    push1(4'h7, 5'd3, 1'b1);
    check("full_count", 32'(fifo_count_o), 32'd4);
    check("full_ready", {31'd0, instr_ready_o}, 32'd0);
    step(1'b1, 4'hD, 5'd0, 1'b1, 1'b0, 1'b0); // refused while full
    vcount = 0;
    gaps   = 0;
    prev_v = 1'b1;
    words.delete();
    for (int i = 0; i < 40; i++) begin
      idle(1);
      if (ctrl_valid_o) begin
        vcount++;
        words.push_back(got_word);
        if (!prev_v) gaps++;
      end
      prev_v = ctrl_valid_o;
    end
    check("drain_cycles", 32'(vcount), 32'd19);
    check("drain_gaps", 32'(gaps), 32'd0);
    if (words.size() == 19) begin
      check("drain_order_1", {19'd0, words[3]},  32'h1800);
      check("drain_order_2", {19'd0, words[7]},  32'h090A);
      check("drain_order_3", {19'd0, words[11]}, 32'h0300);
      check("drain_order_4", {19'd0, words[15]}, 32'h1C05);
    end

    // Flush during a long issue with two queued instructions.
    push1(4'h2, 5'd7, 1'b0);
    push1(4'h5, 5'd0, 1'b0);
    push1(4'h6, 5'd0, 1'b0);
    idle(1);
    step(1'b1, 4'hB, 5'd0, 1'b0, 1'b1, 1'b0);
    check("flush_valid", {31'd0, ctrl_valid_o}, 32'd0);
    check("flush_count", 32'(fifo_count_o), 32'd0);
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    push1(4'h9, 5'd0, 1'b0);
    idle(1);
    check("post_flush_word", {19'd0, got_word}, 32'h0080);
    idle(2);

    // Opcode F followed by opcode 9.
    push1(4'hF, 5'd3, 1'b0);
    push1(4'h9, 5'd0, 1'b0);
`ifdef ALU_ILLEGAL_OPCODE_TRAP_EN
    check("trap_flag", {31'd0, illegal_opcode_o}, 32'd1);
    check("trap_no_issue", {31'd0, ctrl_valid_o}, 32'd0);
    idle(1);
    check("trap_next_word", {19'd0, got_word}, 32'h0080);
    idle(1);
    check("trap_once", {31'd0, ctrl_valid_o}, 32'd0);
    check("trap_sticky", {31'd0, illegal_opcode_o}, 32'd1);
`else
    check("f_word", {19'd0, got_word}, 32'h000A);
    check("f_valid", {31'd0, ctrl_valid_o}, 32'd1);
`endif
    idle(8);

    // Random traffic against the model.
    for (int i = 0; i < 700; i++) begin
      rop  = 4'($urandom_range(0, 15));
      rrep = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      step($urandom_range(0, 2) != 0, rop, rrep, $urandom_range(0, 3) == 0,
           $urandom_range(0, 63) == 0, $urandom_range(0, 127) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
